easyaxi_slv_rd: RTL
===================

EASYAXI_SLV_RD -- requirements
Module: easyaxi_slv_rd

Interface
REQ-001 Parameter OST_DEPTH, default 4, SHALL set the number of accepted AR requests the slave can buffer (power of 2, minimum 2).
REQ-002 Parameter ADDR_LIMIT, default 'h100, SHALL set the first byte address that returns DECERR.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-005 axi_slv_arvalid  input  1; axi_slv_arready  output  1  AR handshake.
REQ-006 axi_slv_arid  input  `AXI_ID_W; axi_slv_araddr  input  `AXI_ADDR_W; axi_slv_arlen  input  `AXI_LEN_W; axi_slv_arsize  input  `AXI_SIZE_W; axi_slv_arburst  input  `AXI_BURST_W  AR payload.
REQ-007 axi_slv_rvalid  output  1; axi_slv_rready  input  1  R handshake.
REQ-008 axi_slv_rid  output  `AXI_ID_W; axi_slv_rdata  output  `AXI_DATA_W; axi_slv_rresp  output  `AXI_RESP_W; axi_slv_rlast  output  1  R payload.

Function
REQ-009 AR handshake (arvalid & arready) SHALL push {id, addr, len, size, burst} into an OST_DEPTH-entry FIFO in the same cycle.
REQ-010 arready SHALL equal ~fifo_full and SHALL be combinational from FIFO state only, never from arvalid.
REQ-011 Responses SHALL be returned strictly in AR acceptance order; rid SHALL equal the arid of the burst being served.
REQ-012 The FSM SHALL have two states: IDLE and BURST.
REQ-013 IDLE, FIFO non-empty: pop head, load beat registers (addr, remaining count = len, id, size, burst), go to BURST; rvalid SHALL be 1 from the next cycle.
REQ-014 Latency: an AR accepted at edge N SHALL produce rvalid=1 at edge N+2 when the FSM is IDLE and the FIFO was empty.
REQ-015 BURST: on R handshake with remaining count > 0, advance the beat address and decrement the count.
REQ-016 BURST: on R handshake of the last beat, if the FIFO is non-empty, pop and load the next burst in the same edge with no bubble (stay in BURST); otherwise go to IDLE and drop rvalid.
REQ-017 rlast SHALL be 1 exactly when the remaining count is 0.
REQ-018 While rvalid & ~rready, rid/rdata/rresp/rlast SHALL hold stable.
REQ-019 A simultaneous push and pop on a full FIFO SHALL NOT occur (arready=0); on a non-full FIFO both SHALL take effect, leaving the occupancy unchanged.
REQ-020 Beat byte count B = 1<<size; FIXED: next = addr; INCR: next = (addr & ~(B-1)) + B, modulo 2^`AXI_ADDR_W.
REQ-021 WRAP: wrap size W = (len+1)*B; next = (addr & ~(W-1)) | ((addr+B) & (W-1)).
REQ-022 rdata SHALL be the current beat address, zero-extended or truncated to `AXI_DATA_W.
REQ-023 rresp per beat: SLVERR if burst = 2'b11, or if burst is WRAP with len not in {1,3,7,15}, or if size > log2(`AXI_DATA_W/8); else DECERR if beat addr >= ADDR_LIMIT; else OKAY.
REQ-024 Error bursts SHALL still return len+1 beats with correct rlast; their address SHALL advance as INCR.

Reset
REQ-025 While rst_n=0 at a clock edge: FIFO empty, FSM in IDLE, beat registers cleared.
REQ-026 After reset: rvalid=0, rlast=0, rid=0, rdata=0, rresp=OKAY, arready=1.
REQ-027 Reset asserted mid-burst SHALL discard all buffered and in-flight bursts without emitting further beats.

Verification
REQ-028 INCR addr 0x10, len 3, size 4B, id 1, rready=1 -> beats rdata 0x10,0x14,0x18,0x1C, rid 1, rresp OKAY, rlast on beat 4, first rvalid 2 cycles after AR.
REQ-029 WRAP addr 0x34, len 3, size 4B -> 0x34,0x38,0x3C,0x30; FIXED addr 0x30, len 3 -> 0x30 x4.
REQ-030 Five ARs with rready=0 and OST_DEPTH=4 -> arready drops after 4 are buffered (head popped into BURST frees one slot, so 5th accepted, 6th stalled); raising rready drains all in order with no bubble between bursts.
REQ-031 Random rready toggling -> payload stable on every stalled cycle; beat count per burst = len+1.
REQ-032 INCR addr 0xF8, len 3, size 4B -> rresp OKAY,OKAY,DECERR,DECERR; burst 2'b11 -> all beats SLVERR, rlast on beat len+1.
REQ-033 rst_n low for 1 cycle during beat 2 of a 4-beat burst -> rvalid=0 next cycle, arready=1, no stale beats afterwards.

Source files
------------

// File: rtl/easyaxi_slv_rd_if.sv
// ============================================================================
// Module      : easyaxi_slv_rd_if
// Description : AXI read-channel (AR + R) bundle for the easyaxi read slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

interface easyaxi_slv_rd_if;
    logic                      axi_slv_arvalid;
    logic                      axi_slv_arready;
    logic [`AXI_ID_W-1:0]      axi_slv_arid;
    logic [`AXI_ADDR_W-1:0]    axi_slv_araddr;
    logic [`AXI_LEN_W-1:0]     axi_slv_arlen;
    logic [`AXI_SIZE_W-1:0]    axi_slv_arsize;
    logic [`AXI_BURST_W-1:0]   axi_slv_arburst;

    logic                      axi_slv_rvalid;
    logic                      axi_slv_rready;
    logic [`AXI_ID_W-1:0]      axi_slv_rid;
    logic [`AXI_DATA_W-1:0]    axi_slv_rdata;
    logic [`AXI_RESP_W-1:0]    axi_slv_rresp;
    logic                      axi_slv_rlast;

    modport master (
        output axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
               axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
        input  axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
               axi_slv_rresp, axi_slv_rlast
    );

    modport slave (
        input  axi_slv_arvalid, axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
               axi_slv_arsize, axi_slv_arburst, axi_slv_rready,
        output axi_slv_arready, axi_slv_rvalid, axi_slv_rid, axi_slv_rdata,
               axi_slv_rresp, axi_slv_rlast
    );
endinterface

`default_nettype wire

// File: rtl/easyaxi_slv_rd.sv
// ============================================================================
// Module      : easyaxi_slv_rd
// Description : AXI read slave; buffers AR requests and answers each burst
//               in order with its beat address as read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv_rd #(
    parameter int                      OST_DEPTH  = 4,
    parameter logic [`AXI_ADDR_W-1:0]  ADDR_LIMIT = 'h100
) (
    input  logic                clk,
    input  logic                rst_n,
    easyaxi_slv_rd_if.slave     axi
);

    localparam int c_PTR_W = $clog2(OST_DEPTH);
    localparam int c_AW    = `AXI_ADDR_W;
    localparam int c_DW    = `AXI_DATA_W;
    localparam int c_LW    = `AXI_LEN_W;
    localparam int c_SW    = `AXI_SIZE_W;

    localparam logic [c_PTR_W:0]            c_PTR_ONE  = 1;
    localparam logic [c_AW-1:0]             c_A_ONE    = 1;
    localparam logic [c_LW-1:0]             c_LEN_ONE  = 1;
    localparam logic [c_LW-1:0]             c_LEN_3    = 3;
    localparam logic [c_LW-1:0]             c_LEN_7    = 7;
    localparam logic [c_LW-1:0]             c_LEN_15   = 15;
    localparam logic [c_SW-1:0]             c_MAX_SIZE = c_SW'($clog2(c_DW / 8));
    localparam logic [`AXI_BURST_W-1:0]     c_FIXED    = 2'b00;
    localparam logic [`AXI_BURST_W-1:0]     c_WRAP     = 2'b10;
    localparam logic [`AXI_BURST_W-1:0]     c_RSVD     = 2'b11;
    localparam logic [`AXI_RESP_W-1:0]      c_OKAY     = 2'b00;
    localparam logic [`AXI_RESP_W-1:0]      c_SLVERR   = 2'b10;
    localparam logic [`AXI_RESP_W-1:0]      c_DECERR   = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [`AXI_ID_W-1:0]    id;
        logic [c_AW-1:0]         addr;
        logic [c_LW-1:0]         len;
        logic [c_SW-1:0]         size;
        logic [`AXI_BURST_W-1:0] burst;
    } ar_t;

    ar_t                      r_mem [OST_DEPTH];
    logic [c_PTR_W:0]         r_wr_ptr;
    logic [c_PTR_W:0]         r_rd_ptr;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_advance;
    ar_t                      w_head;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [`AXI_ID_W-1:0]     r_id;
    logic [c_AW-1:0]          r_addr;
    logic [c_LW-1:0]          r_len;
    logic [c_LW-1:0]          r_cnt;
    logic [c_SW-1:0]          r_size;
    logic [`AXI_BURST_W-1:0]  r_burst;

    logic [c_AW-1:0]          w_bytes;
    logic [c_AW-1:0]          w_wrap_sz;
    logic [c_AW-1:0]          w_addr_incr;
    logic [c_AW-1:0]          w_addr_wrap;
    logic [c_AW-1:0]          w_addr_nxt;
    logic                     w_slverr;
    logic                     w_decerr;
    logic                     w_wrap_len_ok;

    // Full when the pointers differ only in their wrap bit.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_push  = axi.axi_slv_arvalid && !w_full;
    assign w_head  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    assign axi.axi_slv_arready = !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {axi.axi_slv_arid, axi.axi_slv_araddr,
                                             axi.axi_slv_arlen, axi.axi_slv_arsize,
                                             axi.axi_slv_arburst};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (axi.axi_slv_rready) begin
                    if (r_cnt != '0)   w_advance   = 1'b1;
                    else if (!w_empty) w_pop       = 1'b1;
                    else               w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else if (w_pop) begin
            r_id    <= w_head.id;
            r_addr  <= w_head.addr;
            r_len   <= w_head.len;
            r_cnt   <= w_head.len;
            r_size  <= w_head.size;
            r_burst <= w_head.burst;
        end else if (w_advance) begin
            r_addr  <= w_addr_nxt;
            r_cnt   <= r_cnt - c_LEN_ONE;
        end
    end

    assign w_wrap_len_ok = (r_len == c_LEN_ONE) || (r_len == c_LEN_3) ||
                           (r_len == c_LEN_7)   || (r_len == c_LEN_15);
    assign w_slverr = (r_burst == c_RSVD) ||
                      ((r_burst == c_WRAP) && !w_wrap_len_ok) ||
                      (r_size > c_MAX_SIZE);
    assign w_decerr = (r_addr >= ADDR_LIMIT);

    assign w_bytes     = c_A_ONE << r_size;
    assign w_wrap_sz   = (c_AW'(r_len) + c_A_ONE) << r_size;
    assign w_addr_incr = (r_addr & ~(w_bytes - c_A_ONE)) + w_bytes;
    assign w_addr_wrap = (r_addr & ~(w_wrap_sz - c_A_ONE)) |
                         ((r_addr + w_bytes) & (w_wrap_sz - c_A_ONE));

    // Erroneous bursts still walk the address space as INCR.
    always_comb begin
        w_addr_nxt = w_addr_incr;
        if (!w_slverr) begin
            if (r_burst == c_FIXED)     w_addr_nxt = r_addr;
            else if (r_burst == c_WRAP) w_addr_nxt = w_addr_wrap;
        end
    end

    assign axi.axi_slv_rvalid = (r_state == S_BURST);
    assign axi.axi_slv_rlast  = (r_state == S_BURST) && (r_cnt == '0);
    assign axi.axi_slv_rid    = r_id;
    assign axi.axi_slv_rdata  = c_DW'(r_addr);
    assign axi.axi_slv_rresp  = w_slverr ? c_SLVERR : (w_decerr ? c_DECERR : c_OKAY);

endmodule

`default_nettype wire
